// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock types: set/run mode encoding, BCD field limits and a BCD
// increment helper used by the time-of-day counter, display mux and alarm comparator.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN         = 2'd0,
    MODE_SET_HOURS   = 2'd1,
    MODE_SET_MINUTES = 2'd2
  } mode_e;

  localparam logic [7:0] BCD_00 = 8'h00;
  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_59 = 8'h59;

  // Two-digit BCD increment: at limit jump to wrap_value, otherwise ones 9->0 carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                         input logic [7:0] limit,
                                         input logic [7:0] wrap_value);
    logic [7:0] result;
    if (value == limit) begin
      result = wrap_value;
    end else if (value[3:0] == 4'd9) begin
      result = {value[7:4] + 4'd1, 4'd0};
    end else begin
      result = {value[7:4], value[3:0] + 4'd1};
    end
    return result;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle rising-edge pulse on a level synchronous to clock. History resets to 1
// so a level already high when reset releases is not mistaken for an edge.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_reg <= 1'b1;
    end else begin
      prev_reg <= level;
    end
  end

  assign pulse = level & ~prev_reg;

endmodule

// File: rtl/time_of_day_counter.sv
// BCD HH:MM:SS time-of-day counter with a two-button set mode and field blinking.
// 24 h or 12 h (with pm flag) selected by TWELVE_HOUR.
module time_of_day_counter
  import alarm_clock_pkg::*;
#(
  parameter int TWELVE_HOUR = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_1_second,
  input  logic       clock_quarter_second,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic       pm,
  output logic [1:0] mode,
  output logic       blank_hours,
  output logic       blank_minutes,
  output logic       second_tick
);

  localparam logic [7:0] HOUR_RESET = (TWELVE_HOUR != 0) ? BCD_12 : BCD_00;
  localparam logic [7:0] HOUR_MAX   = (TWELVE_HOUR != 0) ? BCD_12 : BCD_23;
  localparam logic [7:0] HOUR_WRAP  = (TWELVE_HOUR != 0) ? BCD_01 : BCD_00;

  logic [2:0] levels;
  logic [2:0] rises;
  logic       tick_rise;
  logic       mode_rise;
  logic       inc_rise;

  assign levels = {inc_btn, mode_btn, clock_1_second};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rise
      rise_detect u_rise (
        .clock (clock),
        .reset (reset),
        .level (levels[gi]),
        .pulse (rises[gi])
      );
    end
  endgenerate

  assign tick_rise = rises[0];
  assign mode_rise = rises[1];
  assign inc_rise  = rises[2];

  mode_e mode_reg;
  mode_e mode_next;
  logic  run_active;
  logic  set_hours_active;
  logic  set_minutes_active;
  logic  clear_seconds;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_reg <= MODE_RUN;
    end else begin
      mode_reg <= mode_next;
    end
  end

  always_comb begin
    mode_next = mode_reg;
    case (mode_reg)
      MODE_RUN:         if (mode_rise) mode_next = MODE_SET_HOURS;
      MODE_SET_HOURS:   if (mode_rise) mode_next = MODE_SET_MINUTES;
      MODE_SET_MINUTES: if (mode_rise) mode_next = MODE_RUN;
      default:          mode_next = MODE_RUN;
    endcase
  end

  always_comb begin
    run_active         = 1'b0;
    set_hours_active   = 1'b0;
    set_minutes_active = 1'b0;
    clear_seconds      = 1'b0;
    case (mode_reg)
      MODE_RUN:         run_active = 1'b1;
      MODE_SET_HOURS:   set_hours_active = 1'b1;
      MODE_SET_MINUTES: begin
        set_minutes_active = 1'b1;
        clear_seconds      = mode_rise;
      end
      default: ;
    endcase
  end

  logic [7:0] hour_reg, hour_next;
  logic [7:0] minute_reg, minute_next;
  logic [7:0] second_reg, second_next;
  logic       pm_reg, pm_next;
  logic       second_tick_reg, second_tick_next;
  logic       blank_hours_reg, blank_minutes_reg;
  logic [7:0] hour_inc;
  logic       pm_inc;

  // pm flips only on the 11 -> 12 step; in 24 h builds it never leaves 0.
  assign hour_inc = bcd_inc(hour_reg, HOUR_MAX, HOUR_WRAP);
  assign pm_inc   = ((TWELVE_HOUR != 0) && (hour_reg == BCD_11)) ? ~pm_reg : pm_reg;

  always_comb begin
    hour_next        = hour_reg;
    minute_next      = minute_reg;
    second_next      = second_reg;
    pm_next          = pm_reg;
    second_tick_next = 1'b0;
    if (run_active && tick_rise) begin
      second_tick_next = 1'b1;
      second_next      = bcd_inc(second_reg, BCD_59, BCD_00);
      if (second_reg == BCD_59) begin
        minute_next = bcd_inc(minute_reg, BCD_59, BCD_00);
        if (minute_reg == BCD_59) begin
          hour_next = hour_inc;
          pm_next   = pm_inc;
        end
      end
    end else if (set_hours_active && inc_rise && !mode_rise) begin
      hour_next = hour_inc;
      pm_next   = pm_inc;
    end else if (set_minutes_active && inc_rise && !mode_rise) begin
      minute_next = bcd_inc(minute_reg, BCD_59, BCD_00);
    end
    if (clear_seconds) begin
      second_next = BCD_00;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hour_reg          <= HOUR_RESET;
      minute_reg        <= BCD_00;
      second_reg        <= BCD_00;
      pm_reg            <= 1'b0;
      second_tick_reg   <= 1'b0;
      blank_hours_reg   <= 1'b0;
      blank_minutes_reg <= 1'b0;
    end else begin
      hour_reg          <= hour_next;
      minute_reg        <= minute_next;
      second_reg        <= second_next;
      pm_reg            <= pm_next;
      second_tick_reg   <= second_tick_next;
      blank_hours_reg   <= set_hours_active & clock_quarter_second;
      blank_minutes_reg <= set_minutes_active & clock_quarter_second;
    end
  end

  assign hour_bcd      = hour_reg;
  assign minute_bcd    = minute_reg;
  assign second_bcd    = second_reg;
  assign pm            = pm_reg;
  assign mode          = mode_reg;
  assign blank_hours   = blank_hours_reg;
  assign blank_minutes = blank_minutes_reg;
  assign second_tick   = second_tick_reg;

endmodule
